// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - shared types and constants for the RV32I fetch stage
package fe_pkg;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2,
        F_ERR  = 2'd3
    } RV32I_FETCH_FSM_t;

    typedef logic [31:0] RV32I_PC_t;

    localparam RV32I_PC_t RV32I_NOP    = 32'h0000_0013;
    localparam RV32I_PC_t RV32I_PC_INC = 32'd4;

    // Instructions are word aligned; any low address bit set is a fault.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fe_pc_reg.sv
// rtl/fe_pc_reg.sv - program counter with redirect / increment / hold selection
module fe_pc_reg
    import fe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    // Only a redirect can carry a bad target; the sequential path is always aligned.
    assign misaligned = redirect & is_misaligned(redirect_pc[1:0]);

    // Redirect beats advance; a misaligned redirect leaves the pc untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            if (!misaligned) begin
                pc <= redirect_pc;
            end
        end else if (advance) begin
            pc <= pc + XLEN'(RV32I_PC_INC);
        end
    end

endmodule

// File: rtl/fe_fetch_unit.sv
// rtl/fe_fetch_unit.sv - multicycle RV32I instruction fetch stage
module fe_fetch_unit
    import fe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i,
    output logic            misaligned_o
);

    RV32I_FETCH_FSM_t state_q, state_d;
    logic             kill_q, kill_d;
    logic             req_q;
    logic             gnt_ok;
    logic             advance;
    logic             capture;
    logic             redirect_bad;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst_q;
    logic [XLEN-1:0]  inst_pc_q;

    fe_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect_i),
        .redirect_pc (redirect_pc_i),
        .advance     (advance),
        .pc          (pc),
        .misaligned  (redirect_bad)
    );

    // A grant only counts while we are actually requesting.
    assign gnt_ok = imem_gnt_i & req_q;

    // Next-state logic; kill marks an issued request whose response must be dropped.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        advance = 1'b0;
        capture = 1'b0;
        case (state_q)
            F_REQ: begin
                if (redirect_i) begin
                    if (redirect_bad) begin
                        state_d = F_ERR;
                        kill_d  = gnt_ok;
                    end else if (gnt_ok) begin
                        state_d = F_WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (gnt_ok) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (redirect_i) begin
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = redirect_bad ? F_ERR : F_REQ;
                    end else begin
                        kill_d = 1'b1;
                        if (redirect_bad) begin
                            state_d = F_ERR;
                        end
                    end
                end else if (imem_rvalid_i) begin
                    kill_d = 1'b0;
                    if (kill_q) begin
                        state_d = F_REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = F_HOLD;
                    end
                end
            end
            F_HOLD: begin
                if (redirect_i) begin
                    state_d = redirect_bad ? F_ERR : F_REQ;
                end else if (inst_ready_i) begin
                    advance = 1'b1;
                    state_d = F_REQ;
                end
            end
            F_ERR: begin
                if (imem_rvalid_i) begin
                    kill_d = 1'b0;
                end
                // If a response is still in flight, drain it before issuing again.
                if (redirect_i && !redirect_bad) begin
                    if (kill_q && !imem_rvalid_i) begin
                        state_d = F_WAIT;
                    end else begin
                        state_d = F_REQ;
                    end
                end
            end
            default: begin
                state_d = F_REQ;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State, kill flag and a registered request so req is low while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= F_REQ;
            kill_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            req_q   <= (state_d == F_REQ);
        end
    end

    // Instruction register loads only on a live response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q    <= XLEN'(RV32I_NOP);
            inst_pc_q <= '0;
        end else if (capture) begin
            inst_q    <= imem_rdata_i;
            inst_pc_q <= pc;
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = pc;
    assign inst_valid_o = (state_q == F_HOLD);
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign misaligned_o = (state_q == F_ERR);

endmodule
